// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signal bundle for the direct-mapped instruction cache.
// The slave modport is the cache's view; master is the CPU/controller/testbench view.
interface icache_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic        if_rdy;
    logic        if_vld;
    logic [31:0] if_inst;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    modport slave (
        input  if_req, if_addr, flush, mc_done, mc_data,
        output if_rdy, if_vld, if_inst, mc_req, mc_addr, hit_cnt, miss_cnt
    );

    modport master (
        output if_req, if_addr, flush, mc_done, mc_data,
        input  if_rdy, if_vld, if_inst, mc_req, mc_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a blocking miss FSM (IDLE/MISS/DRAIN).
// Define ICACHE_STAT_EN to build the hit/miss event counters; otherwise both counters read 0.
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  cif
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

    state_t                  r_state, w_state_nxt;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [31:0]             r_data [LINES];
    logic                    r_if_vld;
    logic [31:0]             r_if_inst;
    logic                    r_mc_req;
    logic [31:0]             r_mc_addr;

    logic [INDEX_BITS-1:0]   w_idx, w_fill_idx;
    logic [TAG_W-1:0]        w_tag, w_fill_tag;
    logic                    w_hit, w_accept, w_fill;
    logic                    w_vld_nxt, w_mc_req_nxt;
    logic [31:0]             w_inst_nxt, w_mc_addr_nxt;
    logic                    w_unused_addr;

    assign w_idx         = cif.if_addr[INDEX_BITS+1:2];
    assign w_tag         = cif.if_addr[31:INDEX_BITS+2];
    assign w_fill_idx    = r_mc_addr[INDEX_BITS+1:2];
    assign w_fill_tag    = r_mc_addr[31:INDEX_BITS+2];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_accept      = (r_state == IDLE) && cif.if_req && !cif.flush;
    assign w_unused_addr = &{1'b0, cif.if_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     r_state <= IDLE;
        else if (rdy) r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt   = r_state;
        w_fill        = 1'b0;
        w_vld_nxt     = 1'b0;
        w_inst_nxt    = r_if_inst;
        w_mc_req_nxt  = r_mc_req;
        w_mc_addr_nxt = r_mc_addr;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_vld_nxt  = 1'b1;
                        w_inst_nxt = r_data[w_idx];
                    end else begin
                        w_state_nxt   = MISS;
                        w_mc_req_nxt  = 1'b1;
                        w_mc_addr_nxt = {cif.if_addr[31:2], 2'b00};
                    end
                end
            end
            MISS: begin
                if (cif.mc_done) begin
                    w_fill       = 1'b1;
                    w_state_nxt  = IDLE;
                    w_mc_req_nxt = 1'b0;
                    if (!cif.flush) begin
                        w_vld_nxt  = 1'b1;
                        w_inst_nxt = cif.mc_data;
                    end
                end else if (cif.flush) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (cif.mc_done) begin
                    w_fill       = 1'b1;
                    w_state_nxt  = IDLE;
                    w_mc_req_nxt = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= '0;
            r_if_vld  <= 1'b0;
            r_if_inst <= '0;
            r_mc_req  <= 1'b0;
            r_mc_addr <= '0;
        end else if (rdy) begin
            r_if_vld  <= w_vld_nxt;
            r_if_inst <= w_inst_nxt;
            r_mc_req  <= w_mc_req_nxt;
            r_mc_addr <= w_mc_addr_nxt;
            if (w_fill) r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data storage is not reset; the cleared valid bits make stale contents unobservable.
    always_ff @(posedge clk) begin
        if (rdy && w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= cif.mc_data;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (rdy && w_accept) begin
            if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
            else       r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign cif.hit_cnt  = r_hit_cnt;
    assign cif.miss_cnt = r_miss_cnt;
`else
    assign cif.hit_cnt  = '0;
    assign cif.miss_cnt = '0;
`endif

    // A pending pulse is shown only in a ready cycle and is squashed by a same-cycle flush.
    assign cif.if_vld  = r_if_vld && rdy && !cif.flush;
    assign cif.if_rdy  = (r_state == IDLE);
    assign cif.if_inst = r_if_inst;
    assign cif.mc_req  = r_mc_req;
    assign cif.mc_addr = r_mc_addr;
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed fetches push expected words; a negedge monitor pops on if_vld.
// Build with or without ICACHE_STAT_EN; counter expectations follow the macro.
module tb_icache;
    logic clk;
    logic rst;
    logic rdy;

    icache_if bus ();

    icache #(.INDEX_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .cif (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    logic [31:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef ICACHE_STAT_EN
        return n;
`else
        return (n == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    // Monitor: every if_vld must match the oldest expected word.
    always @(negedge clk) begin
        if (bus.if_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_if_vld: got inst %h expected no pulse at %0t", bus.if_inst, $time);
            end else begin
                check("if_inst", bus.if_inst, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.if_rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("if_rdy_before_req", {31'd0, bus.if_rdy}, 32'd1);
    endtask

    task automatic wait_report();
        @(negedge clk);
        #1;
        check("vld_reported", exp_q.size(), 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input bit is_hit, input logic [31:0] data);
        wait_idle();
        if (is_hit) exp_q.push_back(data);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        tick();
        bus.if_req  = 1'b0;
        if (is_hit) begin
            exp_hits++;
            check("hit_no_mc_req", {31'd0, bus.mc_req}, 32'd0);
        end else begin
            exp_misses++;
            check("miss_mc_req", {31'd0, bus.mc_req}, 32'd1);
            check("miss_mc_addr", bus.mc_addr, {addr[31:2], 2'b00});
            tick();
            tick();
            check("mc_req_held", {31'd0, bus.mc_req}, 32'd1);
            check("mc_addr_held", bus.mc_addr, {addr[31:2], 2'b00});
            exp_q.push_back(data);
            bus.mc_done = 1'b1;
            bus.mc_data = data;
            tick();
            bus.mc_done = 1'b0;
            check("fill_mc_req_low", {31'd0, bus.mc_req}, 32'd0);
        end
        wait_report();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        rdy         = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.flush   = 1'b0;
        bus.mc_done = 1'b0;
        bus.mc_data = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_if_vld",   {31'd0, bus.if_vld}, 32'd0);
        check("rst_if_inst",  bus.if_inst, 32'd0);
        check("rst_mc_req",   {31'd0, bus.mc_req}, 32'd0);
        check("rst_mc_addr",  bus.mc_addr, 32'd0);
        check("rst_if_rdy",   {31'd0, bus.if_rdy}, 32'd1);
        check("rst_hit_cnt",  bus.hit_cnt, 32'd0);
        check("rst_miss_cnt", bus.miss_cnt, 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Cold fetch, then refetch hits.
        do_fetch(32'h0000_0010, 1'b0, 32'h0050_0093);
        do_fetch(32'h0000_0010, 1'b1, 32'h0050_0093);

        // Conflict on index 4: 0x50 replaces 0x10, which then misses again.
        do_fetch(32'h0000_0050, 1'b0, 32'h00A0_0113);
        do_fetch(32'h0000_0050, 1'b1, 32'h00A0_0113);
        do_fetch(32'h0000_0010, 1'b0, 32'h0050_0093);

        // Flush two cycles into a miss: request held, line installed silently.
        wait_idle();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0020;
        tick();
        bus.if_req  = 1'b0;
        exp_misses++;
        check("flush_miss_mc_req", {31'd0, bus.mc_req}, 32'd1);
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("drain_busy", {31'd0, bus.if_rdy}, 32'd0);
        tick();
        tick();
        check("drain_mc_req_held", {31'd0, bus.mc_req}, 32'd1);
        check("drain_mc_addr_held", bus.mc_addr, 32'h0000_0020);
        bus.mc_done = 1'b1;
        bus.mc_data = 32'h0000_0013;
        tick();
        bus.mc_done = 1'b0;
        check("drain_mc_req_low", {31'd0, bus.mc_req}, 32'd0);
        check("drain_back_idle", {31'd0, bus.if_rdy}, 32'd1);
        @(negedge clk);
        #1;
        check("drain_no_vld", {31'd0, bus.if_vld}, 32'd0);
        do_fetch(32'h0000_0020, 1'b1, 32'h0000_0013);

        // Flush together with a request in IDLE drops it.
        wait_idle();
        bus.if_req  = 1'b1;
        bus.flush   = 1'b1;
        bus.if_addr = 32'h0000_0030;
        tick();
        bus.if_req  = 1'b0;
        bus.flush   = 1'b0;
        check("flush_drop_mc_req", {31'd0, bus.mc_req}, 32'd0);
        check("flush_drop_idle", {31'd0, bus.if_rdy}, 32'd1);

        // Flush in the report cycle of a hit suppresses if_vld (the hit was still accepted).
        wait_idle();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        tick();
        bus.if_req  = 1'b0;
        bus.flush   = 1'b1;
        exp_hits++;
        @(negedge clk);
        #1;
        check("hit_flush_no_vld", {31'd0, bus.if_vld}, 32'd0);
        tick();
        bus.flush = 1'b0;

        // rdy low for three cycles with mc_done pending: frozen, then one pulse.
        wait_idle();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        tick();
        bus.if_req  = 1'b0;
        exp_misses++;
        check("stall_mc_req", {31'd0, bus.mc_req}, 32'd1);
        rdy         = 1'b0;
        bus.mc_done = 1'b1;
        bus.mc_data = 32'h0010_8093;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_frozen_busy", {31'd0, bus.if_rdy}, 32'd0);
            check("stall_mc_req_held", {31'd0, bus.mc_req}, 32'd1);
        end
        exp_q.push_back(32'h0010_8093);
        rdy = 1'b1;
        tick();
        bus.mc_done = 1'b0;
        wait_report();
        tick();
        @(negedge clk);
        #1;
        check("stall_single_vld", {31'd0, bus.if_vld}, 32'd0);

        check("pre_rst_hit_cnt",  bus.hit_cnt,  cnt_exp(exp_hits));
        check("pre_rst_miss_cnt", bus.miss_cnt, cnt_exp(exp_misses));

        // Reset mid-MISS abandons the read; later mc_done is ignored.
        wait_idle();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0060;
        tick();
        bus.if_req  = 1'b0;
        check("rmiss_mc_req", {31'd0, bus.mc_req}, 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("rmiss_mc_req_low", {31'd0, bus.mc_req}, 32'd0);
        check("rmiss_if_vld",     {31'd0, bus.if_vld}, 32'd0);
        check("rmiss_if_rdy",     {31'd0, bus.if_rdy}, 32'd1);
        check("rmiss_mc_addr",    bus.mc_addr, 32'd0);
        check("rmiss_hit_cnt",    bus.hit_cnt, 32'd0);
        tick();
        rst = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
        bus.mc_done = 1'b1;
        bus.mc_data = 32'hDEAD_BEEF;
        tick();
        bus.mc_done = 1'b0;
        check("stray_done_mc_req", {31'd0, bus.mc_req}, 32'd0);
        check("stray_done_idle",   {31'd0, bus.if_rdy}, 32'd1);

        // Everything misses after reset; 3 hits and 2 misses for the counters.
        do_fetch(32'h0000_0010, 1'b0, 32'h0050_0093);
        do_fetch(32'h0000_0010, 1'b1, 32'h0050_0093);
        do_fetch(32'h0000_0010, 1'b1, 32'h0050_0093);
        do_fetch(32'h0000_0050, 1'b0, 32'h00A0_0113);
        do_fetch(32'h0000_0050, 1'b1, 32'h00A0_0113);
        check("hit_cnt",  bus.hit_cnt,  cnt_exp(3));
        check("miss_cnt", bus.miss_cnt, cnt_exp(2));

        tick();
        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, number of index bits (2^INDEX_BITS direct-mapped lines of one 32-bit word each).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rdy  input  1  global ready; low freezes all state.
REQ-005 SHALL have port if_req  input  1  fetch request, sampled only when if_rdy is high.
REQ-006 SHALL have port if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 SHALL have port flush  input  1  squash: drop the in-flight fetch (mispredict).
REQ-008 SHALL have port if_rdy  output  1  high when the cache can accept if_req.
REQ-009 SHALL have port if_vld  output  1  one-cycle pulse: if_inst is valid.
REQ-010 SHALL have port if_inst  output  32  fetched instruction word.
REQ-011 SHALL have port mc_req  output  1  instruction read request to the memory controller (its inst_in_flg).
REQ-012 SHALL have port mc_addr  output  32  word-aligned read address to the memory controller.
REQ-013 SHALL have port mc_done  input  1  memory controller read-complete pulse (its ret_inst_in_flg).
REQ-014 SHALL have port mc_data  input  32  memory controller read data (its ret_res).
REQ-015 SHALL have ports hit_cnt and miss_cnt  output  32 each  event counters (see Configuration).

Function
REQ-016 SHALL split addresses: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]; per line store valid bit, tag, data.
REQ-017 SHALL implement states IDLE, MISS, DRAIN; if_rdy = (state==IDLE).
REQ-018 SHALL, in IDLE with if_req and valid tag match, pulse if_vld with the line data on the next cycle (1-cycle hit latency), staying IDLE.
REQ-019 SHALL, in IDLE with if_req and miss, latch address, go to MISS, and assert mc_req with mc_addr = {addr[31:2],2'b00} starting next cycle.
REQ-020 SHALL hold mc_req high and mc_addr constant throughout MISS and DRAIN until mc_done is sampled; the controller restarts on address change.
REQ-021 SHALL, in MISS on mc_done, write mc_data, set valid and tag of the line, pulse if_vld with if_inst = mc_data next cycle, deassert mc_req, return to IDLE.
REQ-022 SHALL, on flush in MISS, go to DRAIN; in DRAIN on mc_done install the line without if_vld and return to IDLE.
REQ-023 SHALL, on flush with if_req in IDLE, drop the request; flush with mc_done in MISS installs the line, suppresses if_vld, goes IDLE.
REQ-024 SHALL suppress a pending hit if_vld when flush arrives in the cycle the hit would be reported.
REQ-025 SHALL ignore mc_done in IDLE and if_req when if_rdy is low.
REQ-026 SHALL, while rdy is low, hold all registers and outputs; if_vld pulses are not repeated.

Reset
REQ-027 SHALL, on rst low, asynchronously clear all valid bits, state=IDLE, if_vld=0, if_inst=0, mc_req=0, mc_addr=0, hit_cnt=0, miss_cnt=0.
REQ-028 SHALL, on reset mid-MISS, abandon the read with mc_req low; the controller's later mc_done is ignored per REQ-025.

Configuration
REQ-029 SHALL, with macro ICACHE_STAT_EN defined, increment hit_cnt per accepted hit and miss_cnt per accepted miss (mod 2^32 wrap, flush-dropped requests not counted); without it both outputs SHALL be constant 0 and no counter registers exist.

Verification
REQ-030 SHALL cover: cold fetch 0x00000010 -> mc_req with mc_addr 0x00000010 until mc_done data 0x00500093 -> if_vld one cycle later with 0x00500093; refetch -> if_vld next cycle, no mc_req.
REQ-031 SHALL cover: conflict, fetch 0x00000010 then 0x00000050 (same index, INDEX_BITS=4) -> second misses and replaces; refetch 0x00000010 misses again.
REQ-032 SHALL cover: flush two cycles into a miss at 0x00000020 -> mc_req/mc_addr held until mc_done, no if_vld, line then hits.
REQ-033 SHALL cover: rdy low for 3 cycles during MISS with mc_done pending -> no state change, single if_vld after rdy returns.
REQ-034 SHALL cover: rst low mid-MISS -> mc_req, if_vld 0 immediately, all lookups miss after release.
REQ-035 SHALL cover: with ICACHE_STAT_EN, 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2; without it both read 0.
